// File: rtl/blast_clear_module.sv
// Blast sequencer: walks the four flame rays out from a detonated bomb and clears the first block on each ray.
// Out-of-bounds and pillar tiles end a ray with no probe cycle, so the FSM only spends cycles on real map accesses.
module blast_clear_module #(
    parameter int BLAST_RANGE = 2,
    parameter int MAP_COLS    = 33,
    parameter int MAP_ROWS    = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] bomb_col,
    input  logic [4:0] bomb_row,
    input  logic       map_rdata,
    output logic [9:0] waddr,
    output logic       we,
    output logic       busy,
    output logic       done,
    output logic [2:0] ext_u,
    output logic [2:0] ext_r,
    output logic [2:0] ext_d,
    output logic [2:0] ext_l
);

    typedef enum logic [2:0] {IDLE, PROBE, WRITE, NEXT_DIR, DONE} state_t;

    state_t           state_q, state_d;
    logic [5:0]       col_q, col_d;
    logic [4:0]       row_q, row_d;
    logic [1:0]       dir_q, dir_d;
    logic [2:0]       step_q, step_d;
    logic [3:0][2:0]  ext_q, ext_d_w;

    logic [5:0]       cur_col;
    logic [4:0]       cur_row;
    logic [3:0][2:0]  lim;
    logic [9:0]       cand_addr;
    logic [2:0]       nd;

    // Directions: 0=U, 1=R, 2=D, 3=L.
    function automatic logic tile_ok(input logic [1:0] d, input logic [2:0] s,
                                     input logic [5:0] c, input logic [4:0] r);
        int cc;
        int rr;
        cc = int'(c);
        rr = int'(r);
        case (d)
            2'd0:    rr = rr - int'(s);
            2'd1:    cc = cc + int'(s);
            2'd2:    rr = rr + int'(s);
            default: cc = cc - int'(s);
        endcase
        if (cc < 0 || cc >= MAP_COLS || rr < 0 || rr >= MAP_ROWS)
            return 1'b0;
        return !(cc[0] && rr[0]);
    endfunction

    // First direction at or after 'from' that has at least one probeable tile; 4 means none left.
    function automatic logic [2:0] first_dir(input logic [2:0] from, input logic [3:0][2:0] l);
        logic [2:0] res;
        res = 3'd4;
        for (int d = 3; d >= 0; d--)
            if (3'(d) >= from && l[d] != 3'd0)
                res = 3'(d);
        return res;
    endfunction

    // While idle the rays are evaluated on the live bomb inputs so the first probe can start right after the start edge.
    assign cur_col = (state_q == IDLE) ? bomb_col : col_q;
    assign cur_row = (state_q == IDLE) ? bomb_row : row_q;

    // lim[d] = number of consecutive in-bounds, non-pillar tiles on ray d, capped at BLAST_RANGE.
    always_comb begin : ray_limits
        logic ok;
        lim = '0;
        for (int d = 0; d < 4; d++) begin
            ok = 1'b1;
            for (int s = 1; s <= BLAST_RANGE; s++) begin
                if (ok && tile_ok(2'(d), 3'(s), cur_col, cur_row))
                    lim[d] = 3'(s);
                else
                    ok = 1'b0;
            end
        end
    end

    // row*33 as (row<<5)+row.
    always_comb begin : cand_calc
        logic [7:0] cc8;
        logic [7:0] rr8;
        cc8 = {2'b0, col_q};
        rr8 = {3'b0, row_q};
        case (dir_q)
            2'd0:    rr8 = rr8 - {5'b0, step_q};
            2'd1:    cc8 = cc8 + {5'b0, step_q};
            2'd2:    rr8 = rr8 + {5'b0, step_q};
            default: cc8 = cc8 - {5'b0, step_q};
        endcase
        cand_addr = {4'b0, cc8[5:0]} + {rr8[4:0], 5'b0} + {5'b0, rr8[4:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            dir_q   <= '0;
            step_q  <= 3'd1;
            ext_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            ext_q   <= ext_d_w;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dir_d   = dir_q;
        step_d  = step_q;
        ext_d_w = ext_q;
        nd      = 3'd4;
        case (state_q)
            IDLE: begin
                if (start) begin
                    col_d   = bomb_col;
                    row_d   = bomb_row;
                    ext_d_w = '0;
                    step_d  = 3'd1;
                    nd      = first_dir(3'd0, lim);
                    dir_d   = nd[1:0];
                    state_d = (nd == 3'd4) ? DONE : PROBE;
                end
            end
            PROBE: begin
                if (map_rdata) begin
                    ext_d_w[dir_q] = step_q;
                    state_d        = WRITE;
                end else if (step_q == lim[dir_q]) begin
                    // Next tile is blocked, off-map or past range: close this ray and move on in the same edge.
                    ext_d_w[dir_q] = step_q;
                    step_d         = 3'd1;
                    nd             = first_dir({1'b0, dir_q} + 3'd1, lim);
                    dir_d          = nd[1:0];
                    state_d        = (nd == 3'd4) ? DONE : PROBE;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            WRITE: begin
                step_d  = 3'd1;
                nd      = first_dir({1'b0, dir_q} + 3'd1, lim);
                dir_d   = nd[1:0];
                state_d = (nd == 3'd4) ? DONE : PROBE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        waddr = '0;
        we    = 1'b0;
        case (state_q)
            PROBE: waddr = cand_addr;
            WRITE: begin
                waddr = cand_addr;
                we    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign ext_u = ext_q[0];
    assign ext_r = ext_q[1];
    assign ext_d = ext_q[2];
    assign ext_l = ext_q[3];

endmodule

// File: tb/tb_blast_clear_module.sv
// Directed bench for blast_clear_module: probe order, writes, flame lengths, done latency, start/reset corner cases.
module tb_blast_clear_module;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [5:0] bomb_col = '0;
    logic [4:0] bomb_row = '0;
    logic       map_rdata;
    logic [9:0] waddr;
    logic       we, busy, done;
    logic [2:0] ext_u, ext_r, ext_d, ext_l;

    logic blk [0:1023];
    assign map_rdata = blk[waddr];

    blast_clear_module dut (
        .clk(clk), .reset(reset), .start(start), .bomb_col(bomb_col), .bomb_row(bomb_row),
        .map_rdata(map_rdata), .waddr(waddr), .we(we), .busy(busy), .done(done),
        .ext_u(ext_u), .ext_r(ext_r), .ext_d(ext_d), .ext_l(ext_l)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int logw [40];
    int logwe [40];
    int n, done_cyc, pulses;
    int exp_a [16];
    int exp_we [16];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Fires one blast and logs waddr/we for every busy cycle until done (bounded).
    task automatic blast(input int c, input int r, input int poke_at, input int rst_at);
        @(negedge clk);
        bomb_col = c[5:0];
        bomb_row = r[4:0];
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        n        = 0;
        done_cyc = 0;
        while (n < 40 && done_cyc == 0) begin
            if (done) begin
                done_cyc = n + 1;
            end else begin
                logw[n]  = int'(waddr);
                logwe[n] = int'(we);
                if (n == poke_at) begin
                    start    = 1'b1;
                    bomb_col = 6'd10;
                    bomb_row = 5'd10;
                end
                if (n == rst_at) reset = 1'b1;
                n++;
                @(negedge clk);
                start = 1'b0;
                if (reset) begin
                    reset = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic check_seq(input string tag, input int cnt, input int cyc);
        check({tag, "_cycles"}, n, cnt);
        check({tag, "_done_cyc"}, done_cyc, cyc);
        for (int i = 0; i < cnt && i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), logw[i], exp_a[i]);
            check($sformatf("%s_we%0d", tag, i), logwe[i], exp_we[i]);
        end
    endtask

    task automatic check_ext(input string tag, input int u, input int r, input int d, input int l);
        check({tag, "_ext_u"}, int'(ext_u), u);
        check({tag, "_ext_r"}, int'(ext_r), r);
        check({tag, "_ext_d"}, int'(ext_d), d);
        check({tag, "_ext_l"}, int'(ext_l), l);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) blk[i] = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_waddr", int'(waddr), 0);
        check("rst_we", int'(we), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check_ext("rst", 0, 0, 0, 0);
        reset = 1'b0;

        // Empty map, bomb (4,4): U 103,70  R 137,138  D 169,202  L 135,134
        exp_a  = '{103, 70, 137, 138, 169, 202, 135, 134, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_we = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        blast(4, 4, -1, -1);
        check_seq("empty", 8, 9);
        check_ext("empty", 2, 2, 2, 2);

        // Block at (5,4)=137: hit then one write cycle on the same address
        blk[137] = 1'b1;
        exp_a  = '{103, 70, 137, 137, 169, 202, 135, 134, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_we = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        blast(4, 4, -1, -1);
        check_seq("block", 8, 9);
        check_ext("block", 2, 1, 2, 2);
        blk[137] = 1'b0;

        // Bomb (3,4): U/D neighbours are pillars
        exp_a  = '{136, 137, 134, 133, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_we = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        blast(3, 4, -1, -1);
        check_seq("pillar", 4, 5);
        check_ext("pillar", 0, 2, 0, 2);

        // Bomb (0,0), started the cycle after the previous done
        exp_a  = '{1, 2, 33, 66, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        blast(0, 0, -1, -1);
        check_seq("corner", 4, 5);
        check_ext("corner", 0, 2, 2, 0);

        // start re-pulsed mid-blast with a different bomb: ignored
        exp_a  = '{103, 70, 137, 138, 169, 202, 135, 134, 0, 0, 0, 0, 0, 0, 0, 0};
        blast(4, 4, 3, -1);
        check_seq("repulse", 8, 9);
        check_ext("repulse", 2, 2, 2, 2);

        // start held across the DONE edge: ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_start_busy", int'(busy), 0);
        @(negedge clk);
        check("done_start_idle", int'(busy), 0);
        check_ext("done_start", 2, 2, 2, 2);

        // Reset during the WRITE cycle aborts the blast
        blk[137] = 1'b1;
        blast(4, 4, -1, 3);
        check("rst_mid_saw_write", logwe[3], 1);
        check("rst_mid_we", int'(we), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        check_ext("rst_mid", 0, 0, 0, 0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || we) pulses++;
        end
        check("rst_mid_no_activity", pulses, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
